carrier_seq_ctrl: RTL and testbench
===================================

# carrier_seq_ctrl

Programmable sequencer for the carrier generator datapath. A phase accumulator with a runtime tuning word replaces the fixed 32-step address counter, so one waveform ROM (4 banks × 32 samples) can produce variable-frequency carriers. The block runs either continuously or in bursts of N carrier periods, and drives the DAC blank/sync controls. It sits between the host-side configuration logic and the waveform ROM / DAC interface.

## Interface
- ACC_W, 16, phase accumulator width; ACC_W ≥ ADDR_W
- ADDR_W, 5, samples per bank = 2^ADDR_W
- BANK_W, 2, waveform bank select width
- CNT_W, 8, burst period counter width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready
- cfg_step  in  ACC_W  phase increment per clock (tuning word)
- cfg_bank  in  BANK_W  waveform bank
- cfg_cycles  in  CNT_W  burst length in carrier periods; 0 = continuous
- start  in  1  single-cycle start request
- stop  in  1  single-cycle abort request
- busy  out  1  high while in RUN
- done  out  1  single-cycle pulse on burst completion
- rom_addr  out  BANK_W+ADDR_W  {bank, acc[ACC_W-1 -: ADDR_W]}
- blank_DA_n  out  1  DAC blank, low = output blanked
- sync_DA_n  out  1  DAC sync, held high

## Operation
- States: IDLE, RUN, DONE.
- IDLE: cfg_ready = 1; acc = 0; blank_DA_n = 0. A cfg handshake latches step/bank/cycles into shadow registers. start → RUN. stop is ignored.
- If cfg handshake and start occur in the same cycle, the newly offered configuration is used by that run.
- RUN: cfg_ready = 0; cfg_valid is ignored and not stored. Each cycle acc ← acc + step, mod 2^ACC_W. Carry-out of that add marks one carrier period, which increments the period counter.
- Burst end: cycles ≠ 0 and a wrap occurs while count == cycles−1 → DONE.
- stop in RUN → IDLE, with no done pulse.
- start in RUN is ignored.
- stop and burst end in the same cycle → DONE (completion wins).
- DONE: lasts one cycle; done = 1; then → IDLE. start is ignored in DONE.
- step = 0: the address is frozen and no wrap occurs. The block runs until stop, even when cycles ≠ 0.
- Continuous mode (cycles = 0): the period counter is held at 0.
- acc, the period counter, rom_addr, blank_DA_n, busy and done are all registered. Only cfg_ready is combinational from state.

## Timing
- Reset values: state IDLE, acc 0, count 0, shadow regs 0, rom_addr 0, blank_DA_n 0, sync_DA_n 1, busy 0, done 0. cfg_ready reads 1 after reset.
- start sampled at edge k: from edge k+1, busy = 1, blank_DA_n = 1 and rom_addr = {bank, 0}. The address advances from edge k+2.
- Burst end detected at edge m: from edge m+1, busy = 0, done = 1, blank_DA_n = 0 and rom_addr = {bank, 0}. From edge m+2 the block is in IDLE with done = 0.
- stop sampled at edge k: from edge k+1, the block is in IDLE, busy = 0, blank_DA_n = 0 and rom_addr = {bank, 0}.
- A burst of N periods at step S spans N·2^ACC_W/S RUN cycles when S divides 2^ACC_W.
- Reset mid-run: all registers return to reset values immediately; no done pulse.

## Structure
- Shared package carrier_pkg holds the state enum (IDLE/RUN/DONE) and the default widths ACC_W/ADDR_W/BANK_W/CNT_W. The carrier ROM uses the same package.
- One natural sub-module: carrier_phase_acc (accumulator + wrap flag, with clear and enable inputs). The FSM, shadow registers and period counter stay in the top level.

## Test plan
- Reset, then idle: rom_addr = 0, blank_DA_n = 0, sync_DA_n = 1, cfg_ready = 1, busy = 0, done = 0.
- cfg step = 0x0800, bank = 2, cycles = 2, then start: rom_addr = 64, 65, …, 95, 64, … (+1 per clock). done pulses exactly 64 cycles after the first RUN cycle, then the block returns to IDLE.
- Continuous, step = 0x1000: rom_addr increments by 2 per clock and never asserts done. stop → IDLE next cycle, blank_DA_n = 0, no done.
- Same-cycle cfg (bank = 1, cycles = 1) and start: the run uses bank 1, i.e. rom_addr starts at 32. A cfg_valid offered during RUN sees cfg_ready = 0 and does not alter the run.
- stop on the exact cycle of the final wrap: done = 1 for one cycle. step = 0 with cycles = 3: rom_addr is frozen at {bank, 0} until stop.
- reset_n asserted mid-burst: outputs return to reset values immediately, with no done pulse. A new cfg plus start after reset runs normally.

Source files
------------

// File: rtl/carrier_pkg.sv
// Shared types and default widths for the carrier generator datapath.
package carrier_pkg;

  localparam int unsigned ACC_W  = 16;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : carrier_pkg

// File: rtl/carrier_phase_acc.sv
// Phase accumulator: acc advances by step when enabled; wrap_c flags the carry-out of that add.
module carrier_phase_acc
  import carrier_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [ACC_W-1:0]  step,
  output logic [ADDR_W-1:0] phase_msb,
  output logic              wrap_c
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum_c;

  assign sum_c     = {1'b0, acc_q} + {1'b0, step};
  assign wrap_c    = sum_c[ACC_W];
  assign phase_msb = acc_q[ACC_W-1 -: ADDR_W];

  // Next accumulator value: clear has priority over advance.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum_c[ACC_W-1:0];
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule : carrier_phase_acc

// File: rtl/carrier_seq_ctrl.sv
// Carrier sequencer: config shadowing, run/burst FSM, period counting and DAC controls.
module carrier_seq_ctrl
  import carrier_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ACC_W-1:0]         cfg_step,
  input  logic [BANK_W-1:0]        cfg_bank,
  input  logic [CNT_W-1:0]         cfg_cycles,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [BANK_W+ADDR_W-1:0] rom_addr,
  output logic                     blank_DA_n,
  output logic                     sync_DA_n
);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    step_q, step_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                blank_q, blank_d;
  logic                sync_q;

  logic                cfg_fire_c;
  logic                acc_en_c;
  logic                acc_clr_c;
  logic                wrap_c;
  logic                last_period_c;
  logic [ADDR_W-1:0]   phase_msb;

  assign cfg_ready     = (state_q == IDLE);
  assign cfg_fire_c    = cfg_valid & cfg_ready;
  assign acc_en_c      = (state_q == RUN);
  assign acc_clr_c     = (state_d != RUN);
  assign last_period_c = (cycles_q != '0) && (count_q == CNT_W'(cycles_q - CNT_W'(1)));

  carrier_phase_acc u_phase_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (acc_clr_c),
    .en        (acc_en_c),
    .step      (step_q),
    .phase_msb (phase_msb),
    .wrap_c    (wrap_c)
  );

  // Next-state, shadow-register and period-counter logic.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    bank_d   = bank_q;
    cycles_d = cycles_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (cfg_fire_c) begin
          step_d   = cfg_step;
          bank_d   = cfg_bank;
          cycles_d = cfg_cycles;
        end
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cycles_q == '0) begin
          count_d = '0;
        end else if (wrap_c) begin
          count_d = count_q + CNT_W'(1);
        end
        // Completion beats a coincident stop.
        if (wrap_c && last_period_c) begin
          state_d = DONE;
          count_d = '0;
        end else if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
    blank_d = (state_d == RUN);
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      bank_q   <= '0;
      cycles_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      blank_q  <= 1'b0;
      sync_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      bank_q   <= bank_d;
      cycles_q <= cycles_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      blank_q  <= blank_d;
      sync_q   <= 1'b1;
    end
  end

  assign rom_addr   = {bank_q, phase_msb};
  assign busy       = busy_q;
  assign done       = done_q;
  assign blank_DA_n = blank_q;
  assign sync_DA_n  = sync_q;

endmodule : carrier_seq_ctrl

// File: tb/tb_carrier_seq_ctrl.sv
// Scoreboard bench for carrier_seq_ctrl: stimulus queues per-cycle expectations, a monitor checks them.
module tb_carrier_seq_ctrl;
  import carrier_pkg::*;

  logic                     clk;
  logic                     reset_n;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [ACC_W-1:0]         cfg_step;
  logic [BANK_W-1:0]        cfg_bank;
  logic [CNT_W-1:0]         cfg_cycles;
  logic                     start;
  logic                     stop;
  logic                     busy;
  logic                     done;
  logic [BANK_W+ADDR_W-1:0] rom_addr;
  logic                     blank_DA_n;
  logic                     sync_DA_n;

  typedef struct {
    int unsigned cyc;
    string       nm;
    logic [6:0]  addr;
    logic        busy;
    logic        done;
    logic        blank;
    logic        rdy;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc      = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  carrier_seq_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_step   (cfg_step),
    .cfg_bank   (cfg_bank),
    .cfg_cycles (cfg_cycles),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .blank_DA_n (blank_DA_n),
    .sync_DA_n  (sync_DA_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle, mid-cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (mon_e.cyc == cyc && rom_addr == mon_e.addr && busy == mon_e.busy &&
          done == mon_e.done && blank_DA_n == mon_e.blank && sync_DA_n == 1'b1 &&
          cfg_ready == mon_e.rdy) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc=%0d/%0d: got addr=%0d busy=%b done=%b blank_n=%b sync_n=%b rdy=%b; want addr=%0d busy=%b done=%b blank_n=%b sync_n=1 rdy=%b",
                 mon_e.nm, cyc, mon_e.cyc, rom_addr, busy, done, blank_DA_n, sync_DA_n, cfg_ready,
                 mon_e.addr, mon_e.busy, mon_e.done, mon_e.blank, mon_e.rdy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(int unsigned off, string nm, int unsigned a, logic b, logic d,
                          logic bl, logic r);
    exp_t e;
    e.cyc   = cyc + off;
    e.nm    = nm;
    e.addr  = 7'(a);
    e.busy  = b;
    e.done  = d;
    e.blank = bl;
    e.rdy   = r;
    sb_q.push_back(e);
  endtask

  task automatic set_cfg(logic [15:0] s, logic [1:0] b, logic [7:0] c);
    cfg_step   = s;
    cfg_bank   = b;
    cfg_cycles = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    set_cfg(16'h0000, 2'd0, 8'd0);
    tick(); tick();
    push_exp(0, "reset", 0, 0, 0, 0, 1);
    tick();
    reset_n = 1'b1;
    push_exp(1, "idle", 0, 0, 0, 0, 1); tick();

    // Burst: step 0x0800, bank 2, two periods -> 64 RUN cycles.
    set_cfg(16'h0800, 2'd2, 8'd2); cfg_valid = 1'b1;
    push_exp(1, "burst_cfg", 64, 0, 0, 0, 1); tick();
    cfg_valid = 1'b0; start = 1'b1;
    push_exp(1, "burst_run", 64, 1, 0, 1, 0); tick();
    start = 1'b0;
    for (int i = 1; i < 64; i++) begin
      push_exp(1, "burst_run", 64 + (i % 32), 1, 0, 1, 0); tick();
    end
    push_exp(1, "burst_done", 64, 0, 1, 0, 0); tick();
    push_exp(1, "burst_idle", 64, 0, 0, 0, 1); tick();

    // Continuous: step 0x1000, bank 0, cycles 0; stop aborts without done.
    set_cfg(16'h1000, 2'd0, 8'd0); cfg_valid = 1'b1;
    push_exp(1, "cont_cfg", 0, 0, 0, 0, 1); tick();
    cfg_valid = 1'b0; start = 1'b1;
    push_exp(1, "cont_run", 0, 1, 0, 1, 0); tick();
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      push_exp(1, "cont_run", (2 * i) % 32, 1, 0, 1, 0); tick();
    end
    stop = 1'b1;
    push_exp(1, "cont_stop", 0, 0, 0, 0, 1); tick();
    push_exp(1, "stop_in_idle", 0, 0, 0, 0, 1); tick();
    stop = 1'b0;

    // Same-cycle cfg and start; a cfg offered during RUN must not be taken.
    set_cfg(16'h0800, 2'd1, 8'd1); cfg_valid = 1'b1; start = 1'b1;
    push_exp(1, "same_cyc_run", 32, 1, 0, 1, 0); tick();
    start = 1'b0;
    set_cfg(16'h4000, 2'd3, 8'd0);
    for (int i = 1; i < 32; i++) begin
      if (i == 4) cfg_valid = 1'b0;
      push_exp(1, "cfg_in_run", 32 + i, 1, 0, 1, 0); tick();
    end
    push_exp(1, "same_cyc_done", 32, 0, 1, 0, 0); tick();
    push_exp(1, "same_cyc_idle", 32, 0, 0, 0, 1); tick();

    // Stop coincident with final wrap: completion wins; start in DONE ignored.
    start = 1'b1;
    push_exp(1, "stopwrap_run", 32, 1, 0, 1, 0); tick();
    start = 1'b0;
    for (int i = 1; i < 32; i++) begin
      push_exp(1, "stopwrap_run", 32 + i, 1, 0, 1, 0); tick();
    end
    stop = 1'b1;
    push_exp(1, "stopwrap_done", 32, 0, 1, 0, 0); tick();
    stop = 1'b0; start = 1'b1;
    push_exp(1, "start_in_done", 32, 0, 0, 0, 1); tick();
    start = 1'b0;

    // Zero step with cycles 3: frozen address, runs until stop; start in RUN ignored.
    set_cfg(16'h0000, 2'd3, 8'd3); cfg_valid = 1'b1;
    push_exp(1, "zs_cfg", 96, 0, 0, 0, 1); tick();
    cfg_valid = 1'b0; start = 1'b1;
    push_exp(1, "zs_run", 96, 1, 0, 1, 0); tick();
    for (int i = 1; i <= 10; i++) begin
      push_exp(1, "zs_run", 96, 1, 0, 1, 0); tick();
    end
    start = 1'b0; stop = 1'b1;
    push_exp(1, "zs_stop", 96, 0, 0, 0, 1); tick();
    stop = 1'b0;

    // Reset mid-burst: immediate return to reset values, then a normal run.
    set_cfg(16'h0800, 2'd2, 8'd2); cfg_valid = 1'b1; start = 1'b1;
    push_exp(1, "rst_run", 64, 1, 0, 1, 0); tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      push_exp(1, "rst_run", 64 + i, 1, 0, 1, 0); tick();
    end
    tick();
    reset_n = 1'b0;
    push_exp(0, "rst_async", 0, 0, 0, 0, 1);
    push_exp(1, "rst_hold", 0, 0, 0, 0, 1); tick();
    reset_n = 1'b1;
    push_exp(1, "rst_idle", 0, 0, 0, 0, 1); tick();
    set_cfg(16'h1000, 2'd1, 8'd1); cfg_valid = 1'b1; start = 1'b1;
    push_exp(1, "post_rst_run", 32, 1, 0, 1, 0); tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 1; i < 16; i++) begin
      push_exp(1, "post_rst_run", 32 + 2 * i, 1, 0, 1, 0); tick();
    end
    push_exp(1, "post_rst_done", 32, 0, 1, 0, 0); tick();
    push_exp(1, "post_rst_idle", 32, 0, 0, 0, 1); tick();

    tick(); tick();
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb_q.size());
      n_checks += sb_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_carrier_seq_ctrl
